// File: rtl/red_pitaya_trigger_pulse_pkg.sv
// Shared types and constants for the trigger pulse generator: FSM encoding,
// register offsets and register reset defaults.
package red_pitaya_trigger_pulse_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_DELAY   = 3'd1,
      ST_PULSE   = 3'd2,
      ST_HOLDOFF = 3'd3,
      ST_GAP     = 3'd4
   } state_t;

   localparam logic [15:0] OFF_ARM     = 16'h0100;
   localparam logic [15:0] OFF_AUTO    = 16'h0104;
   localparam logic [15:0] OFF_DELAY   = 16'h0108;
   localparam logic [15:0] OFF_WIDTH   = 16'h010C;
   localparam logic [15:0] OFF_HOLDOFF = 16'h0110;
   localparam logic [15:0] OFF_LVL_LO  = 16'h0114;
   localparam logic [15:0] OFF_LVL_HI  = 16'h0118;
   localparam logic [15:0] OFF_BURST_N = 16'h011C;
   localparam logic [15:0] OFF_PERIOD  = 16'h0120;
   localparam logic [15:0] OFF_CTR_LO  = 16'h015C;
   localparam logic [15:0] OFF_CTR_HI  = 16'h0160;
   localparam logic [15:0] OFF_TS_LO   = 16'h0164;
   localparam logic [15:0] OFF_TS_HI   = 16'h0168;
   localparam logic [15:0] OFF_MISSED  = 16'h016C;
   localparam logic [15:0] OFF_CNTBITS = 16'h0220;

   localparam int LEVEL_LOW_RST  = 0;
   localparam int LEVEL_HIGH_RST = 'h1FFF;
   localparam int WIDTH_RST      = 1;

endpackage

// File: rtl/red_pitaya_trigger_pulse_cnt.sv
// Load/decrement down-counter with zero flag, shared by every timed FSM state
// of the trigger pulse generator.
module red_pitaya_trigger_pulse_cnt
   import red_pitaya_trigger_pulse_pkg::*;
#(
   parameter int CNTBITS = 32
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               load,
   input  logic [CNTBITS-1:0] load_val,
   input  logic               dec,
   output logic               zero
);

   localparam logic [CNTBITS-1:0] ONE = CNTBITS'(1);

   logic [CNTBITS-1:0] cnt_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else if (load) begin
         cnt_q <= load_val;
      end else if (dec && !zero) begin
         cnt_q <= cnt_q - ONE;
      end
   end

   assign zero = (cnt_q == '0);

endmodule

// File: rtl/red_pitaya_trigger_pulse_gen.sv
// Trigger-to-pulse generator: armed rising edge on trig_i produces a delayed,
// programmable-width level pulse on dat_o. Optional burst mode: TRIG_PULSE_BURST_EN.
module red_pitaya_trigger_pulse_gen
   import red_pitaya_trigger_pulse_pkg::*;
#(
   parameter int CNTBITS    = 32,
   parameter int SIGNALBITS = 14
) (
   input  logic                         clk_i,
   input  logic                         rst_i,
   input  logic                         trig_i,
   output logic signed [SIGNALBITS-1:0] dat_o,
   output logic                         trig_o,
   output logic                         busy_o,
   input  logic [15:0]                  addr,
   input  logic                         wen,
   input  logic                         ren,
   output logic                         ack,
   output logic [31:0]                  rdata,
   input  logic [31:0]                  wdata
);

   localparam logic [CNTBITS-1:0] ONE = CNTBITS'(1);

   state_t state_q, state_d;

   logic trig_q, trig_edge;
   logic armed_q, arm_wr, fire, hold_done;
   logic in_pulse_q, ts_pend_q, ts_capture;
   logic missed_clr, missed_inc;

   logic                         auto_rearm_r;
   logic [CNTBITS-1:0]           delay_r, width_r, holdoff_r;
   logic signed [SIGNALBITS-1:0] level_low_r, level_high_r;

   logic [CNTBITS-1:0]           width_m1_s, holdoff_s;
   logic signed [SIGNALBITS-1:0] level_low_s, level_high_s;

   logic               cnt_load, cnt_dec, cnt_zero;
   logic [CNTBITS-1:0] cnt_val;

   logic [63:0] ctr_q, ts_q;
   logic [31:0] missed_q, rd_mux;

`ifdef TRIG_PULSE_BURST_EN
   logic [CNTBITS-1:0] burst_n_r, period_r, period_s, rem_q;
   logic               gap_enter;
`endif

   assign trig_edge  = trig_i & ~trig_q;
   assign arm_wr     = wen && (addr == OFF_ARM);
   assign missed_clr = wen && (addr == OFF_MISSED);
   assign missed_inc = trig_edge && !fire;
   assign busy_o     = (state_q != ST_IDLE);
   assign ts_capture = (state_q == ST_PULSE) && !in_pulse_q && ts_pend_q;

   red_pitaya_trigger_pulse_cnt #(
      .CNTBITS (CNTBITS)
   ) u_cnt (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .load     (cnt_load),
      .load_val (cnt_val),
      .dec      (cnt_dec),
      .zero     (cnt_zero)
   );

   always_comb begin
      state_d   = state_q;
      cnt_load  = 1'b0;
      cnt_dec   = 1'b0;
      cnt_val   = '0;
      fire      = 1'b0;
      hold_done = 1'b0;
`ifdef TRIG_PULSE_BURST_EN
      gap_enter = 1'b0;
`endif
      case (state_q)
         ST_IDLE: begin
            if (trig_edge && armed_q) begin
               fire     = 1'b1;
               state_d  = ST_DELAY;
               cnt_load = 1'b1;
               cnt_val  = delay_r;
            end
         end
         ST_DELAY: begin
            if (cnt_zero) begin
               state_d  = ST_PULSE;
               cnt_load = 1'b1;
               cnt_val  = width_m1_s;
            end else begin
               cnt_dec = 1'b1;
            end
         end
         ST_PULSE: begin
            if (cnt_zero) begin
               state_d  = ST_HOLDOFF;
               cnt_load = 1'b1;
               cnt_val  = holdoff_s;
`ifdef TRIG_PULSE_BURST_EN
               if (rem_q > ONE) begin
                  state_d   = ST_GAP;
                  cnt_val   = period_s;
                  gap_enter = 1'b1;
               end
`endif
            end else begin
               cnt_dec = 1'b1;
            end
         end
         ST_HOLDOFF: begin
            if (cnt_zero) begin
               state_d   = ST_IDLE;
               hold_done = 1'b1;
            end else begin
               cnt_dec = 1'b1;
            end
         end
`ifdef TRIG_PULSE_BURST_EN
         ST_GAP: begin
            if (cnt_zero) begin
               state_d  = ST_PULSE;
               cnt_load = 1'b1;
               cnt_val  = width_m1_s;
            end else begin
               cnt_dec = 1'b1;
            end
         end
`endif
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q    <= ST_IDLE;
         trig_q     <= 1'b0;
         armed_q    <= 1'b0;
         in_pulse_q <= 1'b0;
         ts_pend_q  <= 1'b0;
         trig_o     <= 1'b0;
         dat_o      <= '0;
         ctr_q      <= '0;
         ts_q       <= '0;
         missed_q   <= '0;
      end else begin
         state_q    <= state_d;
         trig_q     <= trig_i;
         in_pulse_q <= (state_q == ST_PULSE);
         trig_o     <= (state_q == ST_PULSE) && !in_pulse_q;
         ctr_q      <= ctr_q + 64'd1;

         // Idle output follows the live register; a running shot keeps its snapshot.
         if (state_q == ST_PULSE) begin
            dat_o <= level_high_s;
         end else if (state_q == ST_IDLE) begin
            dat_o <= level_low_r;
         end else begin
            dat_o <= level_low_s;
         end

         if (arm_wr) begin
            armed_q <= 1'b1;
         end else if (fire) begin
            armed_q <= 1'b0;
         end else if (hold_done) begin
            armed_q <= auto_rearm_r | armed_q;
         end

         if (fire) begin
            ts_pend_q <= 1'b1;
         end else if (ts_capture) begin
            ts_pend_q <= 1'b0;
         end
         if (ts_capture) begin
            ts_q <= ctr_q;
         end

         if (missed_clr) begin
            missed_q <= '0;
         end else if (missed_inc && (missed_q != '1)) begin
            missed_q <= missed_q + 32'd1;
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         width_m1_s   <= '0;
         holdoff_s    <= '0;
         level_low_s  <= '0;
         level_high_s <= '0;
`ifdef TRIG_PULSE_BURST_EN
         period_s     <= '0;
         rem_q        <= '0;
`endif
      end else if (fire) begin
         width_m1_s   <= (width_r == '0) ? '0 : width_r - ONE;
         holdoff_s    <= holdoff_r;
         level_low_s  <= level_low_r;
         level_high_s <= level_high_r;
`ifdef TRIG_PULSE_BURST_EN
         period_s     <= period_r;
         rem_q        <= (burst_n_r == '0) ? ONE : burst_n_r;
      end else if (gap_enter) begin
         rem_q        <= rem_q - ONE;
`endif
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         auto_rearm_r <= 1'b0;
         delay_r      <= '0;
         width_r      <= CNTBITS'(WIDTH_RST);
         holdoff_r    <= '0;
         level_low_r  <= SIGNALBITS'(LEVEL_LOW_RST);
         level_high_r <= SIGNALBITS'(LEVEL_HIGH_RST);
`ifdef TRIG_PULSE_BURST_EN
         burst_n_r    <= '0;
         period_r     <= '0;
`endif
      end else if (wen) begin
         case (addr)
            OFF_AUTO:    auto_rearm_r <= wdata[0];
            OFF_DELAY:   delay_r      <= wdata[CNTBITS-1:0];
            OFF_WIDTH:   width_r      <= wdata[CNTBITS-1:0];
            OFF_HOLDOFF: holdoff_r    <= wdata[CNTBITS-1:0];
            OFF_LVL_LO:  level_low_r  <= wdata[SIGNALBITS-1:0];
            OFF_LVL_HI:  level_high_r <= wdata[SIGNALBITS-1:0];
`ifdef TRIG_PULSE_BURST_EN
            OFF_BURST_N: burst_n_r    <= wdata[CNTBITS-1:0];
            OFF_PERIOD:  period_r     <= wdata[CNTBITS-1:0];
`endif
            default: ;
         endcase
      end
   end

   always_comb begin
      rd_mux = '0;
      case (addr)
         OFF_ARM:     rd_mux = {30'd0, busy_o, armed_q};
         OFF_AUTO:    rd_mux = {31'd0, auto_rearm_r};
         OFF_DELAY:   rd_mux[CNTBITS-1:0] = delay_r;
         OFF_WIDTH:   rd_mux[CNTBITS-1:0] = width_r;
         OFF_HOLDOFF: rd_mux[CNTBITS-1:0] = holdoff_r;
         OFF_LVL_LO:  rd_mux[SIGNALBITS-1:0] = level_low_r;
         OFF_LVL_HI:  rd_mux[SIGNALBITS-1:0] = level_high_r;
`ifdef TRIG_PULSE_BURST_EN
         OFF_BURST_N: rd_mux[CNTBITS-1:0] = burst_n_r;
         OFF_PERIOD:  rd_mux[CNTBITS-1:0] = period_r;
`endif
         OFF_CTR_LO:  rd_mux = ctr_q[31:0];
         OFF_CTR_HI:  rd_mux = ctr_q[63:32];
         OFF_TS_LO:   rd_mux = ts_q[31:0];
         OFF_TS_HI:   rd_mux = ts_q[63:32];
         OFF_MISSED:  rd_mux = missed_q;
         OFF_CNTBITS: rd_mux = 32'(CNTBITS);
         default:     rd_mux = '0;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         ack   <= 1'b0;
         rdata <= '0;
      end else begin
         ack <= wen | ren;
         if (ren) begin
            rdata <= rd_mux;
         end
      end
   end

endmodule

// File: tb/tb_red_pitaya_trigger_pulse_gen.sv
// Directed bench for red_pitaya_trigger_pulse_gen: register table plus
// hand-written pulse timing sequences (burst case under TRIG_PULSE_BURST_EN).
module tb_red_pitaya_trigger_pulse_gen;

   localparam logic [13:0] HI = 14'h1FFF;

   typedef struct {
      logic [15:0] addr;
      logic        do_wr;
      logic [31:0] wdata;
      logic [31:0] exp;
   } vec_t;

`ifdef TRIG_PULSE_BURST_EN
   localparam bit BURST = 1'b1;
`else
   localparam bit BURST = 1'b0;
`endif

   logic               clk = 1'b0;
   logic               rst_i, trig_i;
   logic signed [13:0] dat_o;
   logic               trig_o, busy_o;
   logic [15:0]        addr;
   logic               wen, ren, ack;
   logic [31:0]        rdata, wdata;

   int n_cmp = 0;
   int n_bad = 0;
   int edges = 0;
   int hi_cnt = 0;
   int trig_cnt = 0;
   int trig_edge = 0;

   red_pitaya_trigger_pulse_gen dut (
      .clk_i  (clk),
      .rst_i  (rst_i),
      .trig_i (trig_i),
      .dat_o  (dat_o),
      .trig_o (trig_o),
      .busy_o (busy_o),
      .addr   (addr),
      .wen    (wen),
      .ren    (ren),
      .ack    (ack),
      .rdata  (rdata),
      .wdata  (wdata)
   );

   always #5 clk = ~clk;

   always @(posedge clk) edges <= edges + 1;

   always @(negedge clk) begin
      if (dat_o == HI) hi_cnt <= hi_cnt + 1;
      if (trig_o) begin
         trig_cnt  <= trig_cnt + 1;
         trig_edge <= edges;
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic wr(input logic [15:0] a, input logic [31:0] d);
      @(negedge clk);
      addr = a; wdata = d; wen = 1'b1;
      @(posedge clk); #1;
      wen = 1'b0;
   endtask

   task automatic rd(input logic [15:0] a, output logic [31:0] d);
      @(negedge clk);
      addr = a; ren = 1'b1;
      @(posedge clk); #1;
      ren = 1'b0;
      d = rdata;
   endtask

   task automatic ticks(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic trig_run(input int n);
      @(negedge clk);
      trig_i = 1'b1;
      @(posedge clk); #1;
      trig_i = 1'b0;
      ticks(n - 1);
   endtask

   initial begin
      vec_t        vecs[11];
      logic [31:0] d, c;
      int          h0, t0, ep;
      logic [13:0] exp_dat;

      rst_i = 1'b1; trig_i = 1'b0; addr = '0; wen = 1'b0; ren = 1'b0; wdata = '0;
      repeat (3) @(negedge clk);
      rst_i = 1'b0;
      #1;

      chk("rst_dat_o", 64'(dat_o), 64'd0);
      chk("rst_trig_o", 64'(trig_o), 64'd0);
      chk("rst_busy_o", 64'(busy_o), 64'd0);
      chk("rst_ack", 64'(ack), 64'd0);
      chk("rst_rdata", 64'(rdata), 64'd0);
      rd(16'h0100, d); chk("rst_armed", 64'(d), 64'd0);
      rd(16'h010C, d); chk("rst_width", 64'(d), 64'd1);
      rd(16'h0118, d); chk("rst_level_high", 64'(d), 64'h1FFF);

      wr(16'h0108, 32'd1);
      chk("ack_after_write", 64'(ack), 64'd1);
      ticks(1);
      chk("ack_drops", 64'(ack), 64'd0);

      vecs[0]  = '{16'h0108, 1'b1, 32'd7,         32'd7};
      vecs[1]  = '{16'h010C, 1'b1, 32'h12,        32'h12};
      vecs[2]  = '{16'h0110, 1'b1, 32'd3,         32'd3};
      vecs[3]  = '{16'h0114, 1'b1, 32'hFFFF_FFFF, 32'h3FFF};
      vecs[4]  = '{16'h0118, 1'b1, 32'h2ABC,      32'h2ABC};
      vecs[5]  = '{16'h0104, 1'b1, 32'hFFFF_FFFE, 32'd0};
      vecs[6]  = '{16'h0220, 1'b1, 32'h55,        32'd32};
      vecs[7]  = '{16'h0200, 1'b1, 32'h1234,      32'd0};
      vecs[8]  = '{16'h011C, 1'b1, 32'd5,         BURST ? 32'd5 : 32'd0};
      vecs[9]  = '{16'h0120, 1'b1, 32'd9,         BURST ? 32'd9 : 32'd0};
      vecs[10] = '{16'h016C, 1'b0, 32'd0,         32'd0};
      for (int i = 0; i < 11; i++) begin
         if (vecs[i].do_wr) wr(vecs[i].addr, vecs[i].wdata);
         rd(vecs[i].addr, d);
         chk($sformatf("reg_%0h", vecs[i].addr), 64'(d), 64'(vecs[i].exp));
      end
      wr(16'h0114, 32'd0);
      wr(16'h0118, 32'h1FFF);
      wr(16'h011C, 32'd0);
      wr(16'h0120, 32'd0);

      // Basic shot: delay 3, width 5
      wr(16'h0108, 32'd3);
      wr(16'h010C, 32'd5);
      wr(16'h0110, 32'd0);
      wr(16'h0100, 32'd1);
      for (int k = 0; k < 12; k++) begin
         if (k == 0) begin
            @(negedge clk);
            trig_i = 1'b1;
         end
         @(posedge clk); #1;
         trig_i = 1'b0;
         exp_dat = (k >= 5 && k <= 9) ? HI : 14'd0;
         chk($sformatf("wave_dat k=%0d", k), 64'(dat_o), 64'(exp_dat));
         chk($sformatf("wave_trig k=%0d", k), 64'(trig_o), (k == 5) ? 64'd1 : 64'd0);
      end
      ticks(2);
      rd(16'h0164, d);
      rd(16'h015C, c);
      ep = edges;
      chk("timestamp", 64'(d), 64'(c - 32'(ep - trig_edge)));

      // No auto-rearm: second edge is missed
      wr(16'h0108, 32'd0);
      wr(16'h010C, 32'd1);
      wr(16'h016C, 32'd0);
      wr(16'h0100, 32'd1);
      t0 = trig_cnt;
      trig_run(20);
      chk("single_first_pulse", 64'(trig_cnt - t0), 64'd1);
      t0 = trig_cnt;
      trig_run(20);
      chk("single_second_none", 64'(trig_cnt - t0), 64'd0);
      rd(16'h016C, d); chk("single_missed", 64'(d), 64'd1);
      rd(16'h0100, d); chk("single_armed", 64'(d), 64'd0);

      // Arm write and edge in the same cycle
      wr(16'h016C, 32'd0);
      t0 = trig_cnt;
      @(negedge clk);
      addr = 16'h0100; wdata = 32'd1; wen = 1'b1; trig_i = 1'b1;
      @(posedge clk); #1;
      wen = 1'b0; trig_i = 1'b0;
      ticks(6);
      chk("armedge_no_pulse", 64'(trig_cnt - t0), 64'd0);
      rd(16'h016C, d); chk("armedge_missed", 64'(d), 64'd1);
      rd(16'h0100, d); chk("armedge_armed", 64'(d), 64'd1);
      trig_run(10);
      chk("armedge_later_fires", 64'(trig_cnt - t0), 64'd1);

      // Auto-rearm with holdoff
      wr(16'h0104, 32'd1);
      wr(16'h0110, 32'd10);
      wr(16'h016C, 32'd0);
      wr(16'h0100, 32'd1);
      t0 = trig_cnt;
      trig_run(4);
      chk("holdoff_first", 64'(trig_cnt - t0), 64'd1);
      trig_run(16);
      chk("holdoff_ignored", 64'(trig_cnt - t0), 64'd1);
      rd(16'h016C, d); chk("holdoff_missed", 64'(d), 64'd1);
      rd(16'h0100, d); chk("holdoff_rearmed", 64'(d), 64'd1);
      trig_run(6);
      chk("holdoff_after_idle", 64'(trig_cnt - t0), 64'd2);
      ticks(15);

      // Width write during a running pulse applies to the next shot
      wr(16'h0104, 32'd0);
      wr(16'h0110, 32'd0);
      wr(16'h010C, 32'd8);
      wr(16'h0100, 32'd1);
      h0 = hi_cnt;
      @(negedge clk);
      trig_i = 1'b1;
      @(posedge clk); #1;
      trig_i = 1'b0;
      ticks(1);
      wr(16'h010C, 32'd100);
      ticks(15);
      chk("width_old_kept", 64'(hi_cnt - h0), 64'd8);
      wr(16'h0100, 32'd1);
      h0 = hi_cnt;
      trig_run(110);
      chk("width_new_100", 64'(hi_cnt - h0), 64'd100);
      wr(16'h010C, 32'd0);
      wr(16'h0100, 32'd1);
      h0 = hi_cnt;
      t0 = trig_cnt;
      trig_run(6);
      chk("width0_hi", 64'(hi_cnt - h0), 64'd1);
      chk("width0_trig", 64'(trig_cnt - t0), 64'd1);

      // Asynchronous reset in the middle of a pulse
      wr(16'h010C, 32'd20);
      wr(16'h0100, 32'd1);
      trig_run(6);
      chk("pre_rst_high", 64'(dat_o), 64'(HI));
      @(negedge clk);
      #2;
      rst_i = 1'b1;
      #1;
      chk("async_rst_dat", 64'(dat_o), 64'd0);
      chk("async_rst_busy", 64'(busy_o), 64'd0);
      @(negedge clk);
      rst_i = 1'b0;
      rd(16'h0100, d); chk("post_rst_armed", 64'(d), 64'd0);

`ifdef TRIG_PULSE_BURST_EN
      wr(16'h010C, 32'd2);
      wr(16'h011C, 32'd3);
      wr(16'h0120, 32'd4);
      wr(16'h0100, 32'd1);
      h0 = hi_cnt;
      t0 = trig_cnt;
      trig_run(40);
      chk("burst_hi", 64'(hi_cnt - h0), 64'd6);
      chk("burst_trig", 64'(trig_cnt - t0), 64'd3);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
